// File: rtl/sigma_delta_decimator_if.sv
// Bitstream-in / PCM-out bundle for sigma_delta_decimator.
// The master drives the modulator bits, and the slave (the decimator) returns the samples.
interface sigma_delta_decimator_if #(
  parameter int W = 16
);
  logic         din;
  logic         din_en;
  logic [W-1:0] dout;
  logic         dout_valid;

  modport master (output din, output din_en, input dout, input dout_valid);
  modport slave  (input din, input din_en, output dout, output dout_valid);
endinterface

// File: rtl/sigma_delta_decimator.sv
// sinc^ORDER CIC decimator (ratio 2^LOG2R) turning a 1-bit delta-sigma stream into signed W-bit PCM.
// Output scaling rounds half-up when SIGMA_DELTA_DECIMATOR_ROUND_EN is defined, otherwise truncates.
module sigma_delta_decimator #(
  parameter int W     = 16,
  parameter int LOG2R = 6,
  parameter int ORDER = 3
) (
  input logic                    clk,
  input logic                    rst_n,
  sigma_delta_decimator_if.slave bus
);
  localparam int B  = ORDER * LOG2R + 2;
  localparam int S  = ORDER * LOG2R - (W - 1);
  localparam int SR = (S > 0) ? S - 1 : 0;
  localparam logic signed [B:0] MAXV = {{(B - W + 2){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [B:0] MINV = {{(B - W + 2){1'b1}}, {(W - 1){1'b0}}};
`ifdef SIGMA_DELTA_DECIMATOR_ROUND_EN
  localparam logic signed [B:0] RND = (S > 0) ? ({{B{1'b0}}, 1'b1} << SR) : {(B + 1){1'b0}};
`else
  localparam logic signed [B:0] RND = {(B + 1){1'b0}};
`endif

  // Clamp the scaled comb output into the signed W-bit range
  function automatic logic [W-1:0] sat_fn(input logic signed [B:0] v);
    logic [W-1:0] res;
    if (v > MAXV) begin
      res = {1'b0, {(W - 1){1'b1}}};
    end else if (v < MINV) begin
      res = {1'b1, {(W - 1){1'b0}}};
    end else begin
      res = v[W-1:0];
    end
    return res;
  endfunction

  logic signed [B-1:0] r_integ [ORDER];
  logic signed [B-1:0] r_delay [ORDER];
  logic signed [B-1:0] w_cin   [ORDER];
  logic signed [B-1:0] w_x;
  logic signed [B-1:0] w_cout;
  logic signed [B:0]   w_sum;
  logic signed [B:0]   w_y;
  logic [LOG2R-1:0]    r_cnt;
  logic                r_samp;
  logic                r_valid;
  logic [W-1:0]        r_dout;

  // Input mapping, comb chain and output scaling
  always_comb begin
    logic signed [B-1:0] v_acc;
    w_x   = bus.din ? {{(B - 1){1'b0}}, 1'b1} : {B{1'b1}};
    v_acc = r_integ[ORDER-1];
    for (int k = 0; k < ORDER; k++) begin
      w_cin[k] = v_acc;
      v_acc    = v_acc - r_delay[k];
    end
    w_cout = v_acc;
    w_sum  = {w_cout[B-1], w_cout} + RND;
    w_y    = w_sum >>> S;
  end

  // Integrator chain; each stage accumulates the previous-cycle value of the stage before it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ORDER; k++) begin
        r_integ[k] <= {B{1'b0}};
      end
    end else if (bus.din_en) begin
      r_integ[0] <= r_integ[0] + w_x;
      for (int k = 1; k < ORDER; k++) begin
        r_integ[k] <= r_integ[k] + r_integ[k-1];
      end
    end
  end

  // Decimation counter and one-cycle sample strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= {LOG2R{1'b0}};
      r_samp <= 1'b0;
    end else begin
      r_samp <= bus.din_en && (r_cnt == {LOG2R{1'b1}});
      if (bus.din_en) begin
        r_cnt <= r_cnt + LOG2R'(1);
      end
    end
  end

  // Comb delays and the registered, saturated output sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ORDER; k++) begin
        r_delay[k] <= {B{1'b0}};
      end
      r_dout  <= {W{1'b0}};
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_samp;
      if (r_samp) begin
        for (int k = 0; k < ORDER; k++) begin
          r_delay[k] <= w_cin[k];
        end
        r_dout <= sat_fn(w_y);
      end
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_valid;
endmodule
